// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional memory-wait timeout into a sticky ERR state when CPU_CTRL_TIMEOUT_EN is defined.
module cpu_control_fsm #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic [DATA_W-1:0] reg_1,
  input  logic [DATA_W-1:0] reg_2,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  output logic              ir_load,
  output logic              pc_load,
  output logic              pc_src,
  output logic [2:0]        alu_sel,
  output logic              alu_a_sel,
  output logic              alu_b_sel,
  output logic [2:0]        reg_1_sel,
  output logic [2:0]        reg_2_sel,
  output logic [2:0]        rf_wr_sel,
  output logic              rf_we,
  output logic              rf_wdata_sel,
  output logic [2:0]        state,
  output logic              err
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BNE  = 3'd6;
  localparam logic [2:0] OP_J    = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_RSV5   = 3'd5,
    S_RSV6   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, rd_q, rs1_q, rs2_q;
  logic       timed_out;
  logic       unused_ir;

  assign unused_ir = ^ir[3:0];
  assign state     = state_q;

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_mem_wait_state;
  logic             waiting;

  assign in_mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
  assign waiting           = in_mem_wait_state && !mem_ready;
  // The TIMEOUT-th consecutive wait cycle is the one that diverts to ERR.
  assign timed_out         = waiting && (wait_cnt == CNT_LAST);
  assign err               = (state_q == S_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (in_mem_wait_state) begin
      wait_cnt <= '0;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT > 0);
  assign timed_out  = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 3'd0;
      rd_q    <= 3'd0;
      rs1_q   <= 3'd0;
      rs2_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q  <= ir[15:13];
        rd_q  <= ir[12:10];
        rs1_q <= ir[9:7];
        rs2_q <= ir[6:4];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 1'b0;
    alu_sel      = 3'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_1_sel    = 3'd0;
    reg_2_sel    = 3'd0;
    rf_wr_sel    = 3'd0;
    rf_we        = 1'b0;
    rf_wdata_sel = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (timed_out) begin
          state_d = S_ERR;
        end else if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        reg_1_sel = ir[9:7];
        reg_2_sel = ir[6:4];
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        // Keep the read ports on the latched sources so BNE compares stable data.
        reg_1_sel = rs1_q;
        reg_2_sel = rs2_q;
        alu_sel   = op_q;
        case (op_q)
          OP_ADD, OP_SUB, OP_NAND: begin
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_BNE: begin
            if (reg_1 != reg_2) begin
              pc_load   = 1'b1;
              pc_src    = 1'b1;
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            state_d = S_FETCH;
          end
          default: begin
            pc_load   = 1'b1;
            pc_src    = 1'b1;
            alu_b_sel = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        if (timed_out) begin
          state_d = S_ERR;
        end else if (mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        rf_we        = 1'b1;
        rf_wr_sel    = rd_q;
        rf_wdata_sel = (op_q == OP_LW);
        state_d      = S_FETCH;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset forces FETCH, whose request strobe must not escape while reset is held.
    if (reset) begin
      mem_req = 1'b0;
      ir_load = 1'b0;
      pc_load = 1'b0;
    end
  end

endmodule
